// File: rtl/mini16_s2m_collector_if.sv
// Bundle between the S2M collector, the per-PE FIFO pop ports and the master write port.
// The master modport is the collector side; the slave modport is the PE array / memory side.
interface mini16_s2m_collector_if #(
    parameter int WIDTH_D     = 16,
    parameter int DEPTH_V_F   = 16,
    parameter int DEPTH_CORES = 2
);
    localparam int CORES  = 1 << DEPTH_CORES;
    localparam int WORD_W = WIDTH_D + DEPTH_V_F;

    logic [CORES-1:0]        fifo_req_r;
    logic [CORES-1:0]        fifo_valid;
    logic [CORES*WORD_W-1:0] fifo_r_data;
    logic                    m_we;
    logic                    m_ready;
    logic [DEPTH_V_F-1:0]    m_addr;
    logic [WIDTH_D-1:0]      m_data;
    logic [DEPTH_CORES-1:0]  m_core;

    modport master (
        output fifo_req_r,
        input  fifo_valid,
        input  fifo_r_data,
        output m_we,
        input  m_ready,
        output m_addr,
        output m_data,
        output m_core
    );

    modport slave (
        input  fifo_req_r,
        output fifo_valid,
        output fifo_r_data,
        input  m_we,
        output m_ready,
        input  m_addr,
        input  m_data,
        input  m_core
    );
endinterface

// File: rtl/mini16_s2m_collector.sv
// Round-robin drain engine for the mini16 per-PE S2M FIFOs: pops one {addr, data} word at a
// time and presents it on a registered write port tagged with the source core index.
module mini16_s2m_collector #(
    parameter int WIDTH_D     = 16,
    parameter int DEPTH_V_F   = 16,
    parameter int DEPTH_CORES = 2,
    parameter int BURST_MAX   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   soft_reset,
    input  logic                   enable,
    mini16_s2m_collector_if.master bus,
    output logic                   busy,
    output logic [31:0]            word_count
);
    localparam int CORES  = 1 << DEPTH_CORES;
    localparam int WORD_W = WIDTH_D + DEPTH_V_F;
    localparam logic [7:0]             BURST_MAX_C = 8'(BURST_MAX);
    localparam logic [DEPTH_CORES-1:0] PTR_ONE     = DEPTH_CORES'(1);
    localparam logic [CORES-1:0]       REQ_ONE     = CORES'(1);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    function automatic logic [WORD_W-1:0] pick_word(
        input logic [CORES*WORD_W-1:0] all_words,
        input logic [DEPTH_CORES-1:0]  idx
    );
        pick_word = all_words[int'(idx)*WORD_W +: WORD_W];
    endfunction

    state_e                 state_q, state_d;
    logic [DEPTH_CORES-1:0] ptr_q, ptr_d;
    logic [7:0]             burst_q, burst_d;
    logic                   m_we_q, m_we_d;
    logic [DEPTH_V_F-1:0]   m_addr_q, m_addr_d;
    logic [WIDTH_D-1:0]     m_data_q, m_data_d;
    logic [DEPTH_CORES-1:0] m_core_q, m_core_d;
    logic [31:0]            word_count_q, word_count_d;

    logic                   issue_s;
    logic                   accept_s;
    logic                   pop_hit_s;
    logic [WORD_W-1:0]      slice_s;
    logic [CORES-1:0]       fifo_req_s;

    // Handshake qualifiers; request is gated by both resets so it reads 0 while either is active.
    always_comb begin
        issue_s   = reset_n && !soft_reset && enable && (!m_we_q || bus.m_ready);
        accept_s  = m_we_q && bus.m_ready;
        pop_hit_s = (state_q == S_WAIT) && bus.fifo_valid[ptr_q];
        slice_s   = pick_word(bus.fifo_r_data, ptr_q);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_REQ;
        end else if (soft_reset) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (issue_s) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT:  state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    // FSM outputs: a one-hot pop request for exactly the issue cycle.
    always_comb begin
        fifo_req_s = '0;
        case (state_q)
            S_REQ: begin
                if (issue_s) begin
                    fifo_req_s = REQ_ONE << ptr_q;
                end else begin
                    fifo_req_s = '0;
                end
            end
            S_WAIT:  fifo_req_s = '0;
            default: fifo_req_s = '0;
        endcase
    end

    // Scan pointer and burst counter: an empty FIFO or a full burst moves on to the next core.
    always_comb begin
        ptr_d   = ptr_q;
        burst_d = burst_q;
        if (state_q == S_WAIT) begin
            if (bus.fifo_valid[ptr_q]) begin
                if (burst_q + 8'd1 == BURST_MAX_C) begin
                    ptr_d   = ptr_q + PTR_ONE;
                    burst_d = 8'd0;
                end else begin
                    burst_d = burst_q + 8'd1;
                end
            end else begin
                ptr_d   = ptr_q + PTR_ONE;
                burst_d = 8'd0;
            end
        end else begin
            ptr_d   = ptr_q;
            burst_d = burst_q;
        end
    end

    // Output word register: a reload wins over the accept-clear in the same cycle.
    always_comb begin
        m_we_d   = m_we_q;
        m_addr_d = m_addr_q;
        m_data_d = m_data_q;
        m_core_d = m_core_q;
        if (pop_hit_s) begin
            m_we_d   = 1'b1;
            m_addr_d = slice_s[WORD_W-1:WIDTH_D];
            m_data_d = slice_s[WIDTH_D-1:0];
            m_core_d = ptr_q;
        end else if (accept_s) begin
            m_we_d = 1'b0;
        end else begin
            m_we_d = m_we_q;
        end
    end

    // Accepted-word counter, wrapping modulo 2^32.
    always_comb begin
        if (accept_s) begin
            word_count_d = word_count_q + 32'd1;
        end else begin
            word_count_d = word_count_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q        <= '0;
            burst_q      <= 8'd0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_data_q     <= '0;
            m_core_q     <= '0;
            word_count_q <= 32'd0;
        end else if (soft_reset) begin
            ptr_q        <= '0;
            burst_q      <= 8'd0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_data_q     <= '0;
            m_core_q     <= '0;
            word_count_q <= 32'd0;
        end else begin
            ptr_q        <= ptr_d;
            burst_q      <= burst_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_data_q     <= m_data_d;
            m_core_q     <= m_core_d;
            word_count_q <= word_count_d;
        end
    end

    assign bus.fifo_req_r = fifo_req_s;
    assign bus.m_we       = m_we_q;
    assign bus.m_addr     = m_addr_q;
    assign bus.m_data     = m_data_q;
    assign bus.m_core     = m_core_q;
    assign busy           = (state_q == S_WAIT) || m_we_q;
    assign word_count     = word_count_q;

endmodule

// File: tb/tb_mini16_s2m_collector.sv
// Directed bench for mini16_s2m_collector: PE FIFO model with read latency 1, master-side
// monitor, and one task per scenario with hand-computed expectations.
module tb_mini16_s2m_collector;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        soft_reset;
    logic        enable;
    logic        busy;
    logic [31:0] word_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] pe_q [4][$];
    logic [3:0]  req_log [$];
    logic [33:0] rx_q [$];

    mini16_s2m_collector_if #(.WIDTH_D(16), .DEPTH_V_F(16), .DEPTH_CORES(2)) bus ();

    mini16_s2m_collector #(
        .WIDTH_D(16), .DEPTH_V_F(16), .DEPTH_CORES(2), .BURST_MAX(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .soft_reset(soft_reset),
        .enable(enable),
        .bus(bus),
        .busy(busy),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    // PE FIFO model: a request pops the head; valid/data appear in the following cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.fifo_req_r[i] && pe_q[i].size() > 0) begin
                bus.fifo_valid[i]             <= 1'b1;
                bus.fifo_r_data[i*32 +: 32]   <= pe_q[i].pop_front();
            end else begin
                bus.fifo_valid[i]             <= 1'b0;
                bus.fifo_r_data[i*32 +: 32]   <= 32'hDEAD0000 | 32'(i);
            end
        end
    end

    // Request and delivery logs.
    always @(posedge clk) begin
        if (bus.fifo_req_r != 4'b0000) req_log.push_back(bus.fifo_req_r);
        if (bus.m_we && bus.m_ready) rx_q.push_back({bus.m_core, bus.m_addr, bus.m_data});
    end

    task automatic wait_rx(input int n, input int budget);
        for (int c = 0; c < budget && rx_q.size() < n; c++) @(negedge clk);
    endtask

    task automatic wait_mwe(input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (bus.m_we === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic prep();
        @(negedge clk);
        enable     = 1'b0;
        soft_reset = 1'b1;
        @(negedge clk);
        soft_reset = 1'b0;
        for (int i = 0; i < 4; i++) pe_q[i].delete();
        req_log.delete();
        rx_q.delete();
    endtask

    task automatic check_rx(input string name, input logic [33:0] exp [], input int n);
        checks++;
        if (rx_q.size() != n) begin
            failures++;
            $display("FAIL %s_count: got %0d expected %0d", name, rx_q.size(), n);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (rx_q[k] !== exp[k]) begin
                failures++;
                $display("FAIL %s[%0d]: got %h expected %h", name, k, rx_q[k], exp[k]);
            end
        end
    endtask

    task automatic test_reset();
        bit seen;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pe_q[1].push_back(32'h1111_0001);
        pe_q[1].push_back(32'h1111_0002);
        pe_q[1].push_back(32'h1111_0003);
        pe_q[1].push_back(32'h1111_0004);
        bus.m_ready = 1'b1;
        enable      = 1'b1;
        wait_mwe(50, seen);
        checks++;
        if (seen !== 1'b1) begin failures++; $display("FAIL reset_traffic: got %0b expected 1", seen); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.fifo_req_r, bus.m_we, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctl: got req=%b we=%b busy=%b expected all 0", bus.fifo_req_r, bus.m_we, busy);
        end
        checks++;
        if ({bus.m_addr, bus.m_data, bus.m_core} !== 34'd0) begin
            failures++;
            $display("FAIL reset_word: got %h/%h/%h expected 0", bus.m_addr, bus.m_data, bus.m_core);
        end
        checks++;
        if (word_count !== 32'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", word_count); end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.fifo_req_r !== 4'b0000) begin failures++; $display("FAIL reset_hold_req: got %b expected 0000", bus.fifo_req_r); end
        for (int i = 0; i < 4; i++) pe_q[i].delete();
        req_log.delete();
        rx_q.delete();
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (req_log.size() < 1 || req_log[0] !== 4'b0001) begin
            failures++;
            $display("FAIL reset_first_req: got %b (n=%0d) expected 0001", req_log[0], req_log.size());
        end
    endtask

    task automatic test_soft_reset();
        prep();
        pe_q[0].push_back(32'h5000_0001);
        pe_q[0].push_back(32'h5000_0002);
        bus.m_ready = 1'b1;
        enable      = 1'b1;
        wait_rx(2, 60);
        checks++;
        if (word_count !== 32'd2) begin failures++; $display("FAIL srst_precount: got %0d expected 2", word_count); end
        soft_reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({word_count, bus.m_we, busy, bus.fifo_req_r} !== 38'd0) begin
            failures++;
            $display("FAIL srst_state: got cnt=%0d we=%b busy=%b req=%b expected all 0", word_count, bus.m_we, busy, bus.fifo_req_r);
        end
        soft_reset = 1'b0;
        enable     = 1'b0;
    endtask

    task automatic test_scan_order();
        logic [3:0]  exp_req [6] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
        logic [33:0] exp_rx [] = '{{2'd1, 32'h1001_A001}, {2'd1, 32'h1002_A002}, {2'd1, 32'h1003_A003}};
        prep();
        pe_q[1].push_back(32'h1001_A001);
        pe_q[1].push_back(32'h1002_A002);
        pe_q[1].push_back(32'h1003_A003);
        bus.m_ready = 1'b1;
        enable      = 1'b1;
        wait_rx(3, 100);
        repeat (8) @(negedge clk);
        check_rx("scan_rx", exp_rx, 3);
        checks++;
        if (word_count !== 32'd3) begin failures++; $display("FAIL scan_count: got %0d expected 3", word_count); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (req_log[k] !== exp_req[k]) begin
                failures++;
                $display("FAIL scan_req[%0d]: got %b expected %b", k, req_log[k], exp_req[k]);
            end
        end
    endtask

    task automatic test_burst_fairness();
        logic [33:0] exp_rx [] = '{{2'd0, 32'h2001_B001}, {2'd0, 32'h2002_B002}, {2'd0, 32'h2003_B003},
                                   {2'd0, 32'h2004_B004}, {2'd2, 32'h3001_C001}, {2'd0, 32'h2005_B005},
                                   {2'd0, 32'h2006_B006}};
        prep();
        for (int k = 1; k <= 6; k++) pe_q[0].push_back({16'h2000 + 16'(k), 16'hB000 + 16'(k)});
        pe_q[2].push_back(32'h3001_C001);
        bus.m_ready = 1'b1;
        enable      = 1'b1;
        wait_rx(7, 200);
        repeat (8) @(negedge clk);
        check_rx("burst_rx", exp_rx, 7);
    endtask

    task automatic test_backpressure();
        bit seen;
        logic [33:0] exp_rx [] = '{{2'd0, 32'h2001_B001}, {2'd0, 32'h2002_B002},
                                   {2'd0, 32'h2003_B003}, {2'd0, 32'h2004_B004}};
        prep();
        for (int k = 1; k <= 4; k++) pe_q[0].push_back({16'h2000 + 16'(k), 16'hB000 + 16'(k)});
        bus.m_ready = 1'b0;
        enable      = 1'b1;
        wait_mwe(50, seen);
        checks++;
        if (seen !== 1'b1) begin failures++; $display("FAIL bp_first_we: got %0b expected 1", seen); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.m_we, bus.fifo_req_r} !== 5'b1_0000) begin
                failures++;
                $display("FAIL bp_stall_ctl[%0d]: got we=%b req=%b expected we=1 req=0000", c, bus.m_we, bus.fifo_req_r);
            end
            checks++;
            if ({bus.m_core, bus.m_addr, bus.m_data} !== {2'd0, 32'h2001_B001}) begin
                failures++;
                $display("FAIL bp_stall_word[%0d]: got %h/%h/%h expected 0/2001/b001", c, bus.m_core, bus.m_addr, bus.m_data);
            end
        end
        bus.m_ready = 1'b1;
        wait_rx(4, 100);
        repeat (8) @(negedge clk);
        check_rx("bp_rx", exp_rx, 4);
        checks++;
        if (word_count !== 32'd4) begin failures++; $display("FAIL bp_count: got %0d expected 4", word_count); end
    endtask

    task automatic test_enable_drop();
        logic [33:0] exp_rx [] = '{{2'd0, 32'h2001_B001}};
        prep();
        for (int k = 1; k <= 4; k++) pe_q[0].push_back({16'h2000 + 16'(k), 16'hB000 + 16'(k)});
        bus.m_ready = 1'b1;
        enable      = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL en_busy_wait: got %b expected 1", busy); end
        repeat (8) @(negedge clk);
        check_rx("en_rx", exp_rx, 1);
        checks++;
        if (req_log.size() != 1) begin failures++; $display("FAIL en_req_count: got %0d expected 1", req_log.size()); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL en_busy_idle: got %b expected 0", busy); end
        checks++;
        if (word_count !== 32'd1) begin failures++; $display("FAIL en_count: got %0d expected 1", word_count); end
        checks++;
        if (pe_q[0].size() != 3) begin failures++; $display("FAIL en_left: got %0d expected 3", pe_q[0].size()); end
    endtask

    task automatic test_slicing();
        bit seen;
        prep();
        pe_q[3].push_back(32'h8123_BEEF);
        bus.m_ready = 1'b1;
        enable      = 1'b1;
        wait_mwe(50, seen);
        checks++;
        if (seen !== 1'b1) begin failures++; $display("FAIL slice_we: got %0b expected 1", seen); end
        checks++;
        if (bus.m_addr !== 16'h8123) begin failures++; $display("FAIL slice_addr: got %h expected 8123", bus.m_addr); end
        checks++;
        if (bus.m_data !== 16'hBEEF) begin failures++; $display("FAIL slice_data: got %h expected beef", bus.m_data); end
        checks++;
        if (bus.m_core !== 2'd3) begin failures++; $display("FAIL slice_core: got %0d expected 3", bus.m_core); end
        enable = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        soft_reset  = 1'b0;
        enable      = 1'b0;
        bus.m_ready = 1'b0;
        test_reset();
        test_soft_reset();
        test_scan_order();
        test_burst_fairness();
        test_backpressure();
        test_enable_drop();
        test_slicing();
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
